press_decode: RTL
=================

Name: press_decode

Overview:
- Sits directly downstream of the filt3 glitch filter and consumes its filtered level `y` as input `i`.
- Classifies each press of the filtered signal into one of three events:
  - short press: released, and no second press follows within a gap window;
  - long press: held for `LONG_TICKS` cycles;
  - double click: a second press starts inside the gap window.
- Each event is reported as a registered single-cycle pulse for control logic.

Parameters:
- `CNT_W`, 16, width of the shared tick counter.
- `LONG_TICKS`, 1000, press duration in clk cycles that qualifies as a long press. Legal range is 2 to 2**CNT_W-1.
- `DBL_GAP`, 200, release window in clk cycles during which a second press counts as a double click. Legal range is 2 to 2**CNT_W-1.

Ports:
- `clk`, input, 1, sole clock; all logic is on the rising edge.
- `rst`, input, 1, reset, synchronous, active-high.
- `i`, input, 1, filtered press level from the upstream filt3 (`y`); 1 means pressed.
- `short_p`, output, 1, one-cycle pulse for a short press.
- `long_p`, output, 1, one-cycle pulse when a press reaches long duration.
- `dbl_p`, output, 1, one-cycle pulse at the start of a second press within the gap.
- `held`, output, 1, level; high while the block is in state LONG.
- `busy`, output, 1, level; high whenever the state is not IDLE.

Behaviour:
- Interface:
  - Single clock `clk`.
  - Reset is synchronous and active-high.
  - All outputs are registered and updated on the same edge as the state.
- Reset:
  - `rst`=1 at an edge sets state=RELEASE, cnt=0, `short_p`=`long_p`=`dbl_p`=`held`=0 and `busy`=1.
  - `rst` overrides every transition.
  - Reset mid-operation abandons the event in progress and emits no pulse.
- Sampling: `i` is sampled each edge; "sample" below means an edge with `rst`=0.
- States (3-bit encoding) and transitions:
  - RELEASE: `i`=0 → IDLE; otherwise stay.
    - Prevents spurious events when a key is already pressed out of reset.
  - IDLE: `i`=1 → PRESS1, cnt=0.
  - PRESS1:
    - `i`=0 → WAIT2, cnt=0.
    - `i`=1 and cnt==`LONG_TICKS`-1 → LONG, `long_p`=1.
    - Otherwise cnt++.
  - LONG: `held`=1; `i`=0 → IDLE (`held`=0); otherwise stay. No `short_p` is ever emitted for a long press.
  - WAIT2:
    - `i`=1 → DBL, `dbl_p`=1.
    - `i`=0 and cnt==`DBL_GAP`-1 → IDLE, `short_p`=1.
    - Otherwise cnt++.
  - DBL: `i`=0 → IDLE; otherwise stay. A long hold of the second press generates no `long_p`.
  - Undefined encodings → RELEASE.
- Latency:
  - `long_p` is high in the cycle after the (`LONG_TICKS`+1)-th consecutive 1 sample.
  - `short_p` is high after the (`DBL_GAP`+1)-th consecutive 0 sample following release.
  - `dbl_p` is high after the first 1 sample in WAIT2.
- Pulses:
  - Each pulse lasts exactly one cycle.
  - At most one pulse is asserted per cycle.
  - Pulses are mutually exclusive per press sequence.
- Gap boundary: a 1 sample on the same edge where cnt==`DBL_GAP`-1 counts as a double (the `i`=1 check wins).
- Counter rules: cnt never wraps, since it is reset on every phase entry and bounded by the parameters.
- Back-to-back sequences: a press immediately after `short_p` (IDLE at the next edge) starts a fresh PRESS1.

Decomposition:
- Shared package `press_decode_pkg`:
  - state localparams RELEASE=0, IDLE=1, PRESS1=2, LONG=3, WAIT2=4, DBL=5;
  - STATE_W=3.
- No sub-module:
  - one next-state case block plus one registered output/counter block;
  - cnt is shared between PRESS1 and WAIT2.
- filt3 is instantiated beside this block by the integrator, not inside it.

Test Plan (`LONG_TICKS`=8, `DBL_GAP`=4):
1. `rst` for 2 cycles with `i`=1, then `i`=1 for 20 samples → `busy`=1, no pulses; on first `i`=0, state goes to IDLE and `busy`=0 one cycle later.
2. `i`=1 for 3 samples, then 0 → `short_p`=1 for one cycle after the 5th zero sample; `long_p`=`dbl_p`=0; `busy` falls with the pulse.
3. `i`=1 for 12 samples → `long_p` one cycle after the 9th sample; `held`=1 from then until after the first 0 sample; no `short_p` afterwards.
4. `i`: 1×3, 0×2, 1×6, 0 → `dbl_p` after the first sample of the second press; no `short_p` and no `long_p`.
5. Gap boundary: `i`: 1×2, 0×5, 1×1 → `short_p` after the 5th zero. Variant 1×2, 0×4, 1 → `dbl_p` instead of `short_p`.
6. `rst` pulse while in LONG (`i`=1) → `held`=0 the next cycle; no pulses until `i` returns 0 and a new press occurs.

Source files
------------

// File: rtl/press_decode_pkg.sv
// Shared types and constants for the press_decode event classifier.
// State encoding is fixed at 3 bits so the unused codes are explicit and recoverable.
// Event kinds are numbered so a bench or monitor can refer to them by name.
package press_decode_pkg;

  localparam int STATE_W = 3;

  // Decoder states; codes 6 and 7 are unused and fall back to RELEASE.
  typedef enum logic [STATE_W-1:0] {
    RELEASE = 3'd0,
    IDLE    = 3'd1,
    PRESS1  = 3'd2,
    LONG    = 3'd3,
    WAIT2   = 3'd4,
    DBL     = 3'd5
  } state_e;

  // Event kinds, one per output pulse.
  localparam int EVT_SHORT = 0;
  localparam int EVT_LONG  = 1;
  localparam int EVT_DBL   = 2;

endpackage

// File: rtl/press_decode.sv
// Classifies filtered presses into short / long / double-click single-cycle pulses.
// Latency: every output is registered; a pulse appears on the edge that decides the event.
// No backpressure: pulses are fire-and-forget, the consumer must sample every cycle.
module press_decode
  import press_decode_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LONG_TICKS = 1000,
  parameter int DBL_GAP    = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic short_p,
  output logic long_p,
  output logic dbl_p,
  output logic held,
  output logic busy
);

  // Last counter values before the long / gap thresholds are reached.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             held_q, held_d;
  logic             busy_q, busy_d;

  // Next state, shared counter and the pulse/level values the next edge will register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;

    case (state_q)
      // Wait for a release so a key held through reset never produces an event.
      RELEASE: begin
        if (!i) state_d = IDLE;
      end

      IDLE: begin
        if (i) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end

      // Release always wins over the long threshold on the same sample.
      PRESS1: begin
        if (!i) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      LONG: begin
        if (!i) state_d = IDLE;
      end

      // A new press wins over gap expiry on the same sample (boundary counts as double).
      WAIT2: begin
        if (i) begin
          state_d = DBL;
          dbl_d   = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Second press of a double is ignored until released, however long it is held.
      DBL: begin
        if (!i) state_d = IDLE;
      end

      default: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
    endcase

    // Levels track the state being entered so they change on the same edge as it.
    held_d = (state_d == LONG);
    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers; reset drops any event in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      held_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
    end
  end

  assign short_p = short_q;
  assign long_p  = long_q;
  assign dbl_p   = dbl_q;
  assign held    = held_q;
  assign busy    = busy_q;

endmodule
